// File: rtl/sort_sequencer.sv
// sort_sequencer: in-place ascending unsigned bubble sort of len words at base_addr, with early exit
module sort_sequencer #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wdata,
  output logic [15:0]   swap_count,
  output logic [AW-1:0] pass_count
);
  localparam logic [2:0] IDLE = 3'd0, RD_A = 3'd1, RD_B = 3'd2, CMP = 3'd3,
                         WR_A = 3'd4, WR_B = 3'd5, NEXT = 3'd6, FIN = 3'd7;
  logic [2:0]    state;
  logic [AW-1:0] base, j, limit, addr_j, addr_j1;
  logic [DW-1:0] a, b;
  logic          swapped;
  assign addr_j    = base + j;
  assign addr_j1   = addr_j + AW'(1);
  assign busy      = state != IDLE && state != FIN;
  assign done      = state == FIN;
  assign mem_rd_en = state == RD_A || state == RD_B;
  assign mem_wr_en = state == WR_A || state == WR_B;
  assign mem_addr  = (state == RD_A || state == WR_A) ? addr_j :
                     (state == RD_B || state == WR_B) ? addr_j1 : '0;
  assign mem_wdata = state == WR_A ? b : state == WR_B ? a : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      j          <= '0;
      limit      <= '0;
      a          <= '0;
      b          <= '0;
      swapped    <= 1'b0;
      swap_count <= '0;
      pass_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          swap_count <= '0;
          if (len >= AW'(2)) begin
            base       <= base_addr;
            j          <= '0;
            limit      <= len - AW'(1);
            swapped    <= 1'b0;
            pass_count <= AW'(1);
            state      <= RD_A;
          end else begin
            pass_count <= '0;
            state      <= FIN;
          end
        end
        RD_A: state <= RD_B;
        RD_B: begin
          a     <= mem_rdata;
          state <= CMP;
        end
        CMP: begin
          b     <= mem_rdata;
          state <= a > mem_rdata ? WR_A : NEXT;
        end
        WR_A: state <= WR_B;
        WR_B: begin
          swapped <= 1'b1;
          if (swap_count != 16'hFFFF) swap_count <= swap_count + 16'd1;
          state   <= NEXT;
        end
        NEXT: begin
          if (j + AW'(1) < limit) begin
            j     <= j + AW'(1);
            state <= RD_A;
          end else if (!swapped || limit == AW'(1)) begin
            state <= FIN;
          end else begin
            limit      <= limit - AW'(1);
            j          <= '0;
            swapped    <= 1'b0;
            pass_count <= pass_count + AW'(1);
            state      <= RD_A;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_sequencer.sv
// tb_sort_sequencer: directed self-checking bench for sort_sequencer against a word-addressed memory model
module tb_sort_sequencer;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [9:0]  base_addr, len, mem_addr, pass_count;
  logic        busy, done, mem_rd_en, mem_wr_en;
  logic [31:0] mem_rdata, mem_wdata;
  logic [15:0] swap_count;
  logic [31:0] mem [1024];
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  int n_chk = 0, n_err = 0;
  int done_cnt = 0, rd_cnt = 0, wr_cnt = 0, viol = 0;
  logic [31:0] vals10 [10] = '{1000, 800, 23, 384, 342, 234, 0, 65, 9, 290};
  logic [31:0] srt10 [10]  = '{0, 9, 23, 65, 234, 290, 342, 384, 800, 1000};
  sort_sequencer #(.DW(32), .AW(10)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .swap_count(swap_count), .pass_count(pass_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_rd_en ? mem[mem_addr] : 32'd0;
  end
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (mem_rd_en === 1'b1) rd_cnt++;
    if (mem_wr_en === 1'b1) wr_cnt++;
    if (mem_rd_en === 1'b1 && mem_wr_en === 1'b1) viol++;
    if (mem_rd_en === 1'b0 && mem_wr_en === 1'b0 && mem_addr !== 10'd0) viol++;
    if (mem_wr_en === 1'b0 && mem_wdata !== 32'd0) viol++;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic poke(input logic [9:0] addr, input logic [31:0] data);
    @(negedge clk);
    ld_addr = addr;
    ld_data = data;
    ld_en   = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask
  task automatic load10();
    for (int i = 0; i < 10; i++) poke(10'(i), vals10[i]);
  endtask
  task automatic run(input logic [9:0] b, input logic [9:0] l, input bit hold, output int lat);
    @(negedge clk);
    base_addr = b;
    len       = l;
    start     = 1'b1;
    @(posedge clk);
    #1 if (!hold) start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (done !== 1'b1 && lat < 5000);
  endtask
  initial begin
    int lat, d0, r0, w0;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd", mem_rd_en, 0);
    check("rst_wr", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_swaps", swap_count, 0);
    check("rst_passes", pass_count, 0);
    rst = 1'b0;
    load10();
    d0 = done_cnt;
    run(10'd0, 10'd10, 1'b0, lat);
    check("s10_done", done, 1);
    for (int i = 0; i < 10; i++) check($sformatf("s10_mem%0d", i), mem[i], srt10[i]);
    check("s10_swaps", swap_count, 34);
    check("s10_passes", pass_count, 8);
    repeat (3) @(negedge clk);
    check("s10_one_done", done_cnt - d0, 1);
    check("s10_idle_busy", busy, 0);
    check("s10_hold_swaps", swap_count, 34);
    check("s10_hold_passes", pass_count, 8);
    for (int i = 0; i < 4; i++) poke(10'(20 + i), 32'(i + 1));
    w0 = wr_cnt;
    run(10'd20, 10'd4, 1'b0, lat);
    check("sorted_lat", lat, 13);
    check("sorted_no_wr", wr_cnt - w0, 0);
    check("sorted_swaps", swap_count, 0);
    check("sorted_passes", pass_count, 1);
    r0 = rd_cnt; w0 = wr_cnt;
    run(10'd5, 10'd1, 1'b0, lat);
    check("len1_lat", lat, 1);
    check("len1_swaps", swap_count, 0);
    check("len1_passes", pass_count, 0);
    run(10'd5, 10'd0, 1'b0, lat);
    check("len0_lat", lat, 1);
    check("len0_passes", pass_count, 0);
    check("len01_no_strobes", (rd_cnt - r0) + (wr_cnt - w0), 0);
    poke(10'd1022, 32'd3);
    poke(10'd1023, 32'd2);
    poke(10'd0, 32'd1);
    run(10'd1022, 10'd3, 1'b0, lat);
    check("wrap_m1022", mem[1022], 1);
    check("wrap_m1023", mem[1023], 2);
    check("wrap_m0", mem[0], 3);
    check("wrap_swaps", swap_count, 3);
    check("wrap_passes", pass_count, 2);
    load10();
    @(negedge clk);
    base_addr = 10'd0; len = 10'd10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (mem_wr_en !== 1'b1 && lat < 2000);
    check("abort_wr_seen", mem_wr_en, 1);
    @(negedge clk);
    rst = 1'b1;
    d0 = done_cnt;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_wr", mem_wr_en, 0);
    rst = 1'b0;
    w0 = wr_cnt;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_wr", wr_cnt - w0, 0);
    run(10'd0, 10'd10, 1'b0, lat);
    check("resort_done", done, 1);
    for (int i = 0; i < 10; i++) check($sformatf("resort_mem%0d", i), mem[i], srt10[i]);
    d0 = done_cnt;
    run(10'd20, 10'd4, 1'b1, lat);
    check("hold_lat", lat, 13);
    @(negedge clk);
    check("hold_idle_busy", busy, 0);
    check("hold_idle_done", done, 0);
    @(negedge clk);
    check("hold_restart_busy", busy, 1);
    start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (done !== 1'b1 && lat < 5000);
    check("hold_second_lat", lat, 12);
    check("hold_done_total", done_cnt - d0, 2);
    check("hold_passes", pass_count, 1);
    check("strobe_rules", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sort_sequencer.md
SORT_SEQUENCER -- requirements
Module: sort_sequencer

Interface
REQ-001 Parameter: DW, 32, data word width.
REQ-002 Parameter: AW, 10, data memory address width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a sort; sampled only in IDLE.
REQ-006 base_addr  input  AW  word address of element 0; sampled with start.
REQ-007 len  input  AW  element count; sampled with start.
REQ-008 busy  output  1  high in every state other than IDLE and FIN.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 mem_addr  output  AW  data memory word address.
REQ-011 mem_rd_en  output  1  read strobe; mem_rdata is valid on the cycle after the strobe.
REQ-012 mem_rdata  input  DW  read data.
REQ-013 mem_wr_en  output  1  write strobe; the write commits at the posedge ending the cycle.
REQ-014 mem_wdata  output  DW  write data.
REQ-015 swap_count  output  16  swaps performed in the current or last run; saturates at 16'hFFFF.
REQ-016 pass_count  output  AW  passes started in the current or last run.

Function
REQ-017 The block SHALL sort the len words at base_addr ascending, as unsigned values, in place, using bubble sort with early exit.
REQ-018 FSM states SHALL be IDLE, RD_A, RD_B, CMP, WR_A, WR_B, NEXT and FIN.
REQ-019 IDLE with start=1 and len>=2: latch base and len; set j=0, limit=len-1, swapped=0, swap_count=0, pass_count=1; go to RD_A.
REQ-020 IDLE with start=1 and len<2: clear both counters and go to FIN with no memory access.
REQ-021 RD_A: mem_rd_en=1, mem_addr=base+j; go to RD_B.
REQ-022 RD_B: mem_rd_en=1, mem_addr=base+j+1; register a=mem_rdata; go to CMP.
REQ-023 CMP: register b=mem_rdata; if a>mem_rdata go to WR_A, else go to NEXT; equal values SHALL NOT be swapped.
REQ-024 WR_A: mem_wr_en=1, mem_addr=base+j, mem_wdata=b; go to WR_B.
REQ-025 WR_B: mem_wr_en=1, mem_addr=base+j+1, mem_wdata=a; set swapped=1; increment swap_count (saturating); go to NEXT.
REQ-026 NEXT, when j+1<limit: j=j+1; go to RD_A.
REQ-027 NEXT, when j+1==limit and (swapped==0 or limit==1): go to FIN.
REQ-028 NEXT, when j+1==limit and neither exit condition holds: limit=limit-1, j=0, swapped=0, pass_count+1; go to RD_A.
REQ-029 FIN: done=1 for exactly one cycle; go to IDLE.
REQ-030 Timing: a compare without a swap SHALL take 4 cycles; a compare with a swap SHALL take 6 cycles.
REQ-031 start asserted in any state except IDLE SHALL be ignored; it SHALL NOT be queued.
REQ-032 Address arithmetic SHALL wrap modulo 2^AW.
REQ-033 mem_rd_en and mem_wr_en SHALL never be high in the same cycle.
REQ-034 mem_addr and mem_wdata SHALL be 0 when their strobes are low.
REQ-035 swap_count and pass_count SHALL hold their values after done until the next accepted start.

Reset
REQ-036 rst=1 SHALL force state=IDLE, busy=0, done=0, both strobes=0, mem_addr=0, mem_wdata=0, swap_count=0, pass_count=0, j=0, limit=0 at the next posedge.
REQ-037 rst during WR_A/WR_B SHALL suppress any further write from the next cycle on; no done pulse SHALL follow the abort.
REQ-038 rst SHALL take priority over start in the same cycle.

Verification
REQ-039 Scenario: memory 0..9 = 1000,800,23,384,342,234,0,65,9,290; base=0, len=10, start -> final memory 0,9,23,65,234,290,342,384,800,1000; exactly one done pulse.
REQ-040 Scenario: words 1,2,3,4 at base=20, len=4, start accepted at edge k -> no mem_wr_en; done high in cycle k+13; swap_count=0; pass_count=1.
REQ-041 Scenario: len=1 with start at edge k -> done high in cycle k+1; no strobes; counters=0; len=0 gives the same result.
REQ-042 Scenario: words 3,2,1 at base=1022, len=3 -> addresses 1022, 1023, 0 hold 1,2,3; swap_count=3; pass_count=2.
REQ-043 Scenario: rst pulsed in the first WR_B of a 10-element run -> IDLE next cycle, busy=0, no done; a new start then sorts correctly.
REQ-044 Scenario: start held high for the whole run -> one run only; after done, IDLE accepts the still-high start as a new run.
